imu_preprocessor: RTL and testbench
===================================

// Module: imu_preprocessor
// PURPOSE
//  Conditions raw IMU samples (2-axis gyro, 3-axis accel) before the attitude estimator.
//  Per channel: signed offset removal, gain/shift scaling and 16-bit saturation.
//  Accepts one 5-channel sample per AXI4-Stream-style beat (TVALID/TREADY).
//  Holds conditioned outputs for the downstream filter.
// PARAMETERS
//  GYRO_X_OFFSET, GYRO_Y_OFFSET   0    signed 16b bias subtracted from gyro channel
//  ACCL_X_OFFSET, ACCL_Y_OFFSET, ACCL_Z_OFFSET  0  signed 16b bias subtracted from accel channel
//  GYRO_GAIN   1    signed 16b multiplier, both gyro channels
//  ACCL_GAIN   1    signed 16b multiplier, all accel channels
//  GYRO_SHIFT  0    arithmetic right shift after gyro multiply (0..16)
//  ACCL_SHIFT  0    arithmetic right shift after accel multiply (0..16)
//  LPF_SHIFT   2    accel low-pass coefficient 2^-LPF_SHIFT (1..8); used only with PREPROC_LPF_EN
// PORTS
//  clk         in   1   single clock, all logic on rising edge
//  reset       in   1   synchronous, active-low reset
//  RAW_GYRO_X  in   16  raw gyro X, two's complement
//  RAW_GYRO_Y  in   16  raw gyro Y, two's complement
//  RAW_ACCL_X  in   16  raw accel X, two's complement
//  RAW_ACCL_Y  in   16  raw accel Y, two's complement
//  RAW_ACCL_Z  in   16  raw accel Z, two's complement
//  GYRO_X, GYRO_Y  out  16  conditioned gyro, two's complement, registered
//  ACCL_X, ACCL_Y, ACCL_Z  out  16  conditioned accel, two's complement, registered
//  TVALID      in   1   raw sample valid
//  TREADY      out  1   block ready to accept, registered
// BEHAVIOUR
//  - Reset: reset==0 at a clk edge clears all stage registers.
//    Cleared: outputs=0, TREADY=0, accept flag=0, LPF state=0. Reset overrides all other activity.
//  - TREADY=1 from the first edge with reset==1 onward; no back-pressure otherwise.
//  - Accept = TVALID & TREADY. Accepted data goes into stage-1 registers, with s1_new=1.
//    No accept: stage 1 holds and s1_new=0.
//  - Stage 2 runs every cycle from stage 1:
//    d = raw - OFFSET (17b signed); p = d*GAIN (33b signed); q = p >>> SHIFT;
//    out = sat16(q), clamped to [-32768, 32767].
//  - Latency: outputs reflect an accepted sample 2 clk edges after the accepting edge.
//  - Outputs hold the last result while TVALID=0. Back-to-back accepts give one new result per cycle.
//  - Default parameters give identity: out equals raw, 2 cycles late, for the full 16b range.
//  - Reset asserted mid-stream: pipeline contents discarded. Outputs read 0 until 2 cycles after the next accept.
// CONFIGURATION
//  - PREPROC_LPF_EN defined: accel outputs are the state y of a first-order IIR.
//    On each stage-2 cycle with s1_new=1: y <= y + ((x - y) >>> LPF_SHIFT).
//    x is the saturated conditioned value; math is 17b signed; the result always fits 16b.
//    The filter updates only on new samples. State resets to 0. Gyro channels are unfiltered.
//  - PREPROC_LPF_EN undefined: no filter logic; accel outputs equal sat16(q) directly.
// STRUCTURE
//  - Package preproc_pkg holds: SAMPLE_W=16, PROD_W=33, sat16() function, lpf_step() function.
//  - Sub-module preproc_channel: one channel (offset, gain, shift, sat, optional LPF).
//    It takes OFFSET, GAIN, SHIFT, LPF_SHIFT and an LPF_ON bit as parameters.
//    Top level instantiates it 5 times and owns TREADY plus the shared accept/s1_new logic.
// TESTING
//  - Reset: hold reset=0 for 3 cycles with TVALID=1, raw=0x1234.
//    -> all outputs 0 and TREADY 0; TREADY=1 one edge after release.
//  - Identity sweep, defaults: drive raw -32768..32767 on every channel, one per cycle.
//    -> each output equals the input from 2 cycles earlier; no gaps, no mismatches.
//  - Offset/saturation: GYRO_X_OFFSET=100. Raw 1000 -> 900; raw -32768 -> -32768 (clamped);
//    raw 32767 -> 32667.
//  - Gain/shift: ACCL_GAIN=2, ACCL_SHIFT=0. Raw 20000 -> 32767; raw -20000 -> -32768; raw 100 -> 200.
//    With ACCL_SHIFT=1, raw 101 -> 101.
//  - Hold and mid-stream reset: accept 500, then TVALID=0 for 10 cycles -> outputs stay 500.
//    Then pulse reset=0 -> outputs 0, and they stay 0 until a new accept plus 2 cycles.
//  - PREPROC_LPF_EN, LPF_SHIFT=2: accel step 0->1000 on consecutive accepts.
//    -> ACCL_X 250, 437, 577, 682. Gyro tracks the step unfiltered.

Source files
------------

// File: rtl/imu_preprocessor_pkg.sv
// Shared definitions for the IMU sample preprocessor: widths, the per-beat
// sample bundle, 16-bit saturation and the first-order low-pass step.
package preproc_pkg;

    localparam int SAMPLE_W = 16;
    localparam int DIFF_W   = 17;
    localparam int PROD_W   = 33;

    localparam logic signed [PROD_W-1:0] SAT_MAX = 33'sd32767;
    localparam logic signed [PROD_W-1:0] SAT_MIN = -33'sd32768;

    // One beat of five IMU channels, used both for raw inputs and conditioned results
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] gyroX;
        logic signed [SAMPLE_W-1:0] gyroY;
        logic signed [SAMPLE_W-1:0] acclX;
        logic signed [SAMPLE_W-1:0] acclY;
        logic signed [SAMPLE_W-1:0] acclZ;
    } sample_t;

    // Clamp a scaled product into the signed 16-bit output range
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [PROD_W-1:0] q);
        logic signed [SAMPLE_W-1:0] result;
        if (q > SAT_MAX) begin
            result = 16'sh7FFF;
        end else if (q < SAT_MIN) begin
            result = 16'sh8000;
        end else begin
            result = SAMPLE_W'(q);
        end
        return result;
    endfunction

    // One IIR step y + ((x - y) >>> k); the result lies between y and x, so it fits 16 bits
    function automatic logic signed [SAMPLE_W-1:0] lpf_step(
        input logic signed [SAMPLE_W-1:0] y,
        input logic signed [SAMPLE_W-1:0] x,
        input int                         k
    );
        logic signed [DIFF_W-1:0] diff;
        logic signed [DIFF_W-1:0] step;
        logic signed [DIFF_W-1:0] sum;
        diff = DIFF_W'(x) - DIFF_W'(y);
        step = diff >>> k;
        sum  = DIFF_W'(y) + step;
        return SAMPLE_W'(sum);
    endfunction

endpackage

// File: rtl/imu_preprocessor_if.sv
// Sample bus of the IMU preprocessor: raw channels with TVALID/TREADY in,
// conditioned channels out. The master drives raw data, the slave is the block.
interface imu_preprocessor_if;
    import preproc_pkg::*;

    logic signed [SAMPLE_W-1:0] RAW_GYRO_X;
    logic signed [SAMPLE_W-1:0] RAW_GYRO_Y;
    logic signed [SAMPLE_W-1:0] RAW_ACCL_X;
    logic signed [SAMPLE_W-1:0] RAW_ACCL_Y;
    logic signed [SAMPLE_W-1:0] RAW_ACCL_Z;
    logic                       TVALID;
    logic                       TREADY;
    logic signed [SAMPLE_W-1:0] GYRO_X;
    logic signed [SAMPLE_W-1:0] GYRO_Y;
    logic signed [SAMPLE_W-1:0] ACCL_X;
    logic signed [SAMPLE_W-1:0] ACCL_Y;
    logic signed [SAMPLE_W-1:0] ACCL_Z;

    modport master (
        output RAW_GYRO_X, RAW_GYRO_Y, RAW_ACCL_X, RAW_ACCL_Y, RAW_ACCL_Z, TVALID,
        input  TREADY, GYRO_X, GYRO_Y, ACCL_X, ACCL_Y, ACCL_Z
    );

    modport slave (
        input  RAW_GYRO_X, RAW_GYRO_Y, RAW_ACCL_X, RAW_ACCL_Y, RAW_ACCL_Z, TVALID,
        output TREADY, GYRO_X, GYRO_Y, ACCL_X, ACCL_Y, ACCL_Z
    );

endinterface

// File: rtl/imu_preprocessor_channel.sv
// One conditioning lane: capture on accept, subtract offset, multiply by gain
// (registered), then arithmetic shift, saturate and optionally low-pass filter
// into the output register. The output only moves when a new sample arrives.
module preproc_channel
    import preproc_pkg::*;
#(
    parameter logic signed [15:0] OFFSET    = 16'sd0,
    parameter logic signed [15:0] GAIN      = 16'sd1,
    parameter int                 SHIFT     = 0,
    parameter int                 LPF_SHIFT = 2,
    parameter bit                 LPF_ON    = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_accept,
    input  logic                       i_s2New,
    input  logic signed [SAMPLE_W-1:0] i_raw,
    output logic signed [SAMPLE_W-1:0] o_sample
);

    localparam logic signed [DIFF_W-1:0] OFFSET_EXT = DIFF_W'(OFFSET);
    localparam logic signed [PROD_W-1:0] GAIN_EXT   = PROD_W'(GAIN);

    logic signed [SAMPLE_W-1:0] r_s1Raw;
    logic signed [PROD_W-1:0]   r_s2Prod;
    logic signed [SAMPLE_W-1:0] r_out;
    logic signed [DIFF_W-1:0]   w_diff;
    logic signed [PROD_W-1:0]   w_shifted;
    logic signed [SAMPLE_W-1:0] w_sat;
    logic signed [SAMPLE_W-1:0] w_next;

    assign w_diff    = DIFF_W'(r_s1Raw) - OFFSET_EXT;
    assign w_shifted = r_s2Prod >>> SHIFT;
    assign w_sat     = sat16(w_shifted);
    // LPF_ON is constant, so the filter datapath is pruned entirely when it is 0
    assign w_next    = LPF_ON ? lpf_step(r_out, w_sat, LPF_SHIFT) : w_sat;
    assign o_sample  = r_out;

    // Stage 1: latch the raw sample only on an accepted beat, otherwise hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1Raw <= '0;
        end else if (i_accept) begin
            r_s1Raw <= i_raw;
        end
    end

    // Stage 2: offset removal and gain multiply, re-evaluated every cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s2Prod <= '0;
        end else begin
            r_s2Prod <= PROD_W'(w_diff) * GAIN_EXT;
        end
    end

    // Output: shift, saturate and filter, updated only when a fresh sample reaches it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out <= '0;
        end else if (i_s2New) begin
            r_out <= w_next;
        end
    end

endmodule

// File: rtl/imu_preprocessor.sv
// IMU preprocessor top: accepts one 5-channel beat per TVALID/TREADY handshake
// and produces offset-corrected, scaled, saturated channels two edges later.
// Optional build macro PREPROC_LPF_EN adds a first-order low-pass filter on the
// three accel channels; gyro channels are never filtered.
module imu_preprocessor
    import preproc_pkg::*;
#(
    parameter logic signed [15:0] GYRO_X_OFFSET = 16'sd0,
    parameter logic signed [15:0] GYRO_Y_OFFSET = 16'sd0,
    parameter logic signed [15:0] ACCL_X_OFFSET = 16'sd0,
    parameter logic signed [15:0] ACCL_Y_OFFSET = 16'sd0,
    parameter logic signed [15:0] ACCL_Z_OFFSET = 16'sd0,
    parameter logic signed [15:0] GYRO_GAIN     = 16'sd1,
    parameter logic signed [15:0] ACCL_GAIN     = 16'sd1,
    parameter int                 GYRO_SHIFT    = 0,
    parameter int                 ACCL_SHIFT    = 0,
    parameter int                 LPF_SHIFT     = 2
) (
    input logic                clk,
    input logic                reset,
    imu_preprocessor_if.slave  io_bus
);

`ifdef PREPROC_LPF_EN
    localparam bit ACCL_LPF_ON = 1'b1;
`else
    localparam bit ACCL_LPF_ON = 1'b0;
`endif

    logic    r_tready;
    logic    r_s1New;
    logic    r_s2New;
    logic    w_accept;
    sample_t w_raw;
    sample_t w_cond;

    assign w_accept = io_bus.TVALID & r_tready;

    assign w_raw.gyroX = io_bus.RAW_GYRO_X;
    assign w_raw.gyroY = io_bus.RAW_GYRO_Y;
    assign w_raw.acclX = io_bus.RAW_ACCL_X;
    assign w_raw.acclY = io_bus.RAW_ACCL_Y;
    assign w_raw.acclZ = io_bus.RAW_ACCL_Z;

    assign io_bus.TREADY = r_tready;
    assign io_bus.GYRO_X = w_cond.gyroX;
    assign io_bus.GYRO_Y = w_cond.gyroY;
    assign io_bus.ACCL_X = w_cond.acclX;
    assign io_bus.ACCL_Y = w_cond.acclY;
    assign io_bus.ACCL_Z = w_cond.acclZ;

    // Ready rises one edge after reset release and never drops; there is no back-pressure
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tready <= 1'b0;
        end else begin
            r_tready <= 1'b1;
        end
    end

    // New-sample flags travel alongside the data so the output stage knows when to update
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1New <= 1'b0;
            r_s2New <= 1'b0;
        end else begin
            r_s1New <= w_accept;
            r_s2New <= r_s1New;
        end
    end

    preproc_channel #(
        .OFFSET(GYRO_X_OFFSET), .GAIN(GYRO_GAIN), .SHIFT(GYRO_SHIFT),
        .LPF_SHIFT(LPF_SHIFT), .LPF_ON(1'b0)
    ) u_gyroX (
        .clk(clk), .reset(reset), .i_accept(w_accept), .i_s2New(r_s2New),
        .i_raw(w_raw.gyroX), .o_sample(w_cond.gyroX)
    );

    preproc_channel #(
        .OFFSET(GYRO_Y_OFFSET), .GAIN(GYRO_GAIN), .SHIFT(GYRO_SHIFT),
        .LPF_SHIFT(LPF_SHIFT), .LPF_ON(1'b0)
    ) u_gyroY (
        .clk(clk), .reset(reset), .i_accept(w_accept), .i_s2New(r_s2New),
        .i_raw(w_raw.gyroY), .o_sample(w_cond.gyroY)
    );

    preproc_channel #(
        .OFFSET(ACCL_X_OFFSET), .GAIN(ACCL_GAIN), .SHIFT(ACCL_SHIFT),
        .LPF_SHIFT(LPF_SHIFT), .LPF_ON(ACCL_LPF_ON)
    ) u_acclX (
        .clk(clk), .reset(reset), .i_accept(w_accept), .i_s2New(r_s2New),
        .i_raw(w_raw.acclX), .o_sample(w_cond.acclX)
    );

    preproc_channel #(
        .OFFSET(ACCL_Y_OFFSET), .GAIN(ACCL_GAIN), .SHIFT(ACCL_SHIFT),
        .LPF_SHIFT(LPF_SHIFT), .LPF_ON(ACCL_LPF_ON)
    ) u_acclY (
        .clk(clk), .reset(reset), .i_accept(w_accept), .i_s2New(r_s2New),
        .i_raw(w_raw.acclY), .o_sample(w_cond.acclY)
    );

    preproc_channel #(
        .OFFSET(ACCL_Z_OFFSET), .GAIN(ACCL_GAIN), .SHIFT(ACCL_SHIFT),
        .LPF_SHIFT(LPF_SHIFT), .LPF_ON(ACCL_LPF_ON)
    ) u_acclZ (
        .clk(clk), .reset(reset), .i_accept(w_accept), .i_s2New(r_s2New),
        .i_raw(w_raw.acclZ), .o_sample(w_cond.acclZ)
    );

endmodule

// File: tb/tb_imu_preprocessor.sv
// Testbench for imu_preprocessor: three differently parameterised instances
// share one stimulus stream; a scoreboard of expected beats is filled on each
// accepted input and drained as results reach the outputs.
`timescale 1ns/1ps
module tb_imu_preprocessor;

    localparam int NDUT = 3;
    localparam int NCH  = 5;
    localparam int OBSW = NDUT * NCH * 16 + NDUT;

    typedef logic [NDUT*NCH-1:0][15:0] expBeat_t;

    // Instance parameters: A defaults, B gyro-X offset 100 and accel gain 2, C accel gain 2 shift 1
    localparam int MOFF   [NDUT][NCH] = '{'{0, 0, 0, 0, 0}, '{100, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
    localparam int MGAIN  [NDUT][NCH] = '{'{1, 1, 1, 1, 1}, '{1, 1, 2, 2, 2}, '{1, 1, 2, 2, 2}};
    localparam int MSHIFT [NDUT][NCH] = '{'{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 1, 1, 1}};

`ifdef PREPROC_LPF_EN
    localparam bit MODEL_LPF = 1'b1;
`else
    localparam bit MODEL_LPF = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic                drvValid;
    logic signed [15:0]  drvRaw [NCH];
    logic                modelReady;
    logic [2:0]          pipe;
    expBeat_t            curExp;
    expBeat_t            sbQ [$];
    int                  lpfY [NDUT][NCH];
    int                  testsRun;
    int                  testsFailed;
    logic [OBSW-1:0]     obsVec;

    imu_preprocessor_if busA ();
    imu_preprocessor_if busB ();
    imu_preprocessor_if busC ();

    imu_preprocessor dutA (.clk(clk), .reset(reset), .io_bus(busA));

    imu_preprocessor #(
        .GYRO_X_OFFSET(16'sd100), .ACCL_GAIN(16'sd2), .ACCL_SHIFT(0)
    ) dutB (.clk(clk), .reset(reset), .io_bus(busB));

    imu_preprocessor #(
        .ACCL_GAIN(16'sd2), .ACCL_SHIFT(1)
    ) dutC (.clk(clk), .reset(reset), .io_bus(busC));

    assign busA.RAW_GYRO_X = drvRaw[0];
    assign busA.RAW_GYRO_Y = drvRaw[1];
    assign busA.RAW_ACCL_X = drvRaw[2];
    assign busA.RAW_ACCL_Y = drvRaw[3];
    assign busA.RAW_ACCL_Z = drvRaw[4];
    assign busA.TVALID     = drvValid;
    assign busB.RAW_GYRO_X = drvRaw[0];
    assign busB.RAW_GYRO_Y = drvRaw[1];
    assign busB.RAW_ACCL_X = drvRaw[2];
    assign busB.RAW_ACCL_Y = drvRaw[3];
    assign busB.RAW_ACCL_Z = drvRaw[4];
    assign busB.TVALID     = drvValid;
    assign busC.RAW_GYRO_X = drvRaw[0];
    assign busC.RAW_GYRO_Y = drvRaw[1];
    assign busC.RAW_ACCL_X = drvRaw[2];
    assign busC.RAW_ACCL_Y = drvRaw[3];
    assign busC.RAW_ACCL_Z = drvRaw[4];
    assign busC.TVALID     = drvValid;

    assign obsVec = {busA.TREADY, busB.TREADY, busC.TREADY,
                     busA.GYRO_X, busA.GYRO_Y, busA.ACCL_X, busA.ACCL_Y, busA.ACCL_Z,
                     busB.GYRO_X, busB.GYRO_Y, busB.ACCL_X, busB.ACCL_Y, busB.ACCL_Z,
                     busC.GYRO_X, busC.GYRO_Y, busC.ACCL_X, busC.ACCL_Y, busC.ACCL_Z};

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference arithmetic in wide integers: subtract, multiply, shift, clamp
    function automatic int condModel(input int raw, input int off, input int gain, input int sh);
        longint p;
        p = longint'(raw - off) * longint'(gain);
        p = p >>> sh;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    function automatic logic [OBSW-1:0] expVec();
        return {{NDUT{modelReady}}, curExp};
    endfunction

    // Advance one clock: update the reference model at the edge, then move to the falling edge
    task automatic tick();
        logic     acc;
        expBeat_t b;
        int       x;
        @(posedge clk);
        acc = drvValid && modelReady && reset;
        if (!reset) begin
            modelReady = 1'b0;
            pipe       = '0;
            curExp     = '0;
            sbQ.delete();
            foreach (lpfY[d, c]) lpfY[d][c] = 0;
        end else begin
            modelReady = 1'b1;
            pipe       = {pipe[1:0], acc};
            if (acc) begin
                b = '0;
                for (int d = 0; d < NDUT; d++) begin
                    for (int c = 0; c < NCH; c++) begin
                        x = condModel(int'(drvRaw[c]), MOFF[d][c], MGAIN[d][c], MSHIFT[d][c]);
                        if (MODEL_LPF && c >= 2) begin
                            lpfY[d][c] = lpfY[d][c] + ((x - lpfY[d][c]) >>> 2);
                            x = lpfY[d][c];
                        end
                        b[NDUT*NCH-1-(d*NCH+c)] = 16'(x);
                    end
                end
                sbQ.push_back(b);
            end
            if (pipe[2] && sbQ.size() > 0) curExp = sbQ.pop_front();
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input int r0, input int r1, input int r2,
                                 input int r3, input int r4);
        drvValid  = valid;
        drvRaw[0] = 16'(r0);
        drvRaw[1] = 16'(r1);
        drvRaw[2] = 16'(r2);
        drvRaw[3] = 16'(r3);
        drvRaw[4] = 16'(r4);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        applyStimulus(1'b1, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (obsVec !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_clear: got %h expected 0", obsVec);
            end
        end
        reset = 1'b1;
        tick();
        testsRun++;
        if ({busA.TREADY, busB.TREADY, busC.TREADY} !== 3'b111) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready_rise: got %b expected 111",
                     {busA.TREADY, busB.TREADY, busC.TREADY});
        end
        testsRun++;
        if (obsVec !== expVec()) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_sb: got %h expected %h", obsVec, expVec());
        end
        drvValid = 1'b0;
    endtask

    task automatic test_identity_sweep();
        for (int v = 0; v < 65536; v++) begin
            applyStimulus(1'b1, v - 32768, v, v + 13107, v + 26214, v + 39321);
            tick();
            testsRun++;
            if (obsVec !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL sweep_sb v=%0d: got %h expected %h", v, obsVec, expVec());
            end
            if (v >= 2) begin
                testsRun++;
                if (busA.GYRO_X !== 16'(v - 2 - 32768)) begin
                    testsFailed++;
                    $display("[TB] FAIL sweep_identity v=%0d: got %0d expected %0d",
                             v, busA.GYRO_X, v - 2 - 32768);
                end
            end
            if (testsFailed > 100) break;
        end
        drvValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (obsVec !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL sweep_drain: got %h expected %h", obsVec, expVec());
            end
        end
    endtask

    task automatic test_offset_gain_sat();
        int gx     [4] = '{1000, -32768, 32767, 0};
        int ax     [4] = '{20000, -20000, 100, 101};
        int expBgx [4] = '{900, -32768, 32667, -100};
        int expBax [4] = '{32767, -32768, 200, 202};
        int expCax [4] = '{20000, -20000, 100, 101};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, gx[i], gx[i], ax[i], ax[i], ax[i]);
            for (int t = 0; t < 3; t++) begin
                tick();
                drvValid = 1'b0;
                testsRun++;
                if (obsVec !== expVec()) begin
                    testsFailed++;
                    $display("[TB] FAIL offset_gain_sb beat=%0d: got %h expected %h",
                             i, obsVec, expVec());
                end
            end
            testsRun++;
            if (busB.GYRO_X !== 16'(expBgx[i])) begin
                testsFailed++;
                $display("[TB] FAIL offset_sat beat=%0d: got %0d expected %0d",
                         i, busB.GYRO_X, expBgx[i]);
            end
`ifndef PREPROC_LPF_EN
            testsRun++;
            if (busB.ACCL_X !== 16'(expBax[i])) begin
                testsFailed++;
                $display("[TB] FAIL gain_sat beat=%0d: got %0d expected %0d",
                         i, busB.ACCL_X, expBax[i]);
            end
            testsRun++;
            if (busC.ACCL_X !== 16'(expCax[i])) begin
                testsFailed++;
                $display("[TB] FAIL gain_shift beat=%0d: got %0d expected %0d",
                         i, busC.ACCL_X, expCax[i]);
            end
`endif
        end
    endtask

    task automatic test_hold_and_reset();
        applyStimulus(1'b1, 500, 500, 500, 500, 500);
        for (int t = 0; t < 12; t++) begin
            tick();
            drvValid = 1'b0;
            testsRun++;
            if (obsVec !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL hold_sb t=%0d: got %h expected %h", t, obsVec, expVec());
            end
            if (t >= 2) begin
                testsRun++;
                if (busA.GYRO_X !== 16'sd500) begin
                    testsFailed++;
                    $display("[TB] FAIL hold_value t=%0d: got %0d expected 500", t, busA.GYRO_X);
                end
            end
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        testsRun++;
        if (obsVec !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_clear: got %h expected 0", obsVec);
        end
        for (int t = 0; t < 7; t++) begin
            if (t == 5) applyStimulus(1'b1, 700, 700, 700, 700, 700);
            tick();
            drvValid = 1'b0;
            testsRun++;
            if (obsVec[OBSW-NDUT-1:0] !== '0) begin
                testsFailed++;
                $display("[TB] FAIL midreset_zero t=%0d: got %h expected 0", t, obsVec);
            end
        end
        tick();
        testsRun++;
        if (busA.GYRO_X !== 16'sd700) begin
            testsFailed++;
            $display("[TB] FAIL midreset_resume: got %0d expected 700", busA.GYRO_X);
        end
        testsRun++;
        if (obsVec !== expVec()) begin
            testsFailed++;
            $display("[TB] FAIL midreset_sb: got %h expected %h", obsVec, expVec());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            if (i < 32) begin
                applyStimulus(1'b1, int'($urandom), int'($urandom), int'($urandom),
                              int'($urandom), int'($urandom));
            end else begin
                drvValid = 1'b0;
            end
            tick();
            testsRun++;
            if (obsVec !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL back_to_back i=%0d: got %h expected %h", i, obsVec, expVec());
            end
        end
    endtask

`ifdef PREPROC_LPF_EN
    task automatic test_lpf_step();
        int lpfExp [4] = '{250, 437, 577, 682};
        reset = 1'b0;
        drvValid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i < 4, 1000, 1000, 1000, 1000, 1000);
            tick();
            testsRun++;
            if (obsVec !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL lpf_sb i=%0d: got %h expected %h", i, obsVec, expVec());
            end
            if (i >= 2 && i < 6) begin
                testsRun++;
                if (busA.ACCL_X !== 16'(lpfExp[i-2])) begin
                    testsFailed++;
                    $display("[TB] FAIL lpf_step i=%0d: got %0d expected %0d",
                             i, busA.ACCL_X, lpfExp[i-2]);
                end
                testsRun++;
                if (busA.GYRO_X !== 16'sd1000) begin
                    testsFailed++;
                    $display("[TB] FAIL lpf_gyro_unfiltered i=%0d: got %0d expected 1000",
                             i, busA.GYRO_X);
                end
            end
        end
        drvValid = 1'b0;
    endtask
`endif

    // Test sequence
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        modelReady  = 1'b0;
        pipe        = '0;
        curExp      = '0;
        foreach (lpfY[d, c]) lpfY[d][c] = 0;
        reset       = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 0, 0);
        @(negedge clk);

        test_reset();
        test_identity_sweep();
        test_offset_gain_sat();
        test_hold_and_reset();
        test_back_to_back();
`ifdef PREPROC_LPF_EN
        test_lpf_step();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
